pixel_draw_engine: RTL and testbench
====================================

// Module: pixel_draw_engine
// PURPOSE
//  Parametrised drawing FSM between user controls (switches/keys) and vga_adapter.
//  Draws a single pixel, filled rectangle, rectangle outline or full-screen clear,
//  emitting one (x, y, colour, plot) write per clock in raster order.
//  Coordinates are clamped to the screen and corners auto-ordered, so the top level
//  no longer needs its own clamp logic.
// PARAMETERS
//  X_RES    160  horizontal pixels; valid x = 0..X_RES-1
//  Y_RES    120  vertical pixels; valid y = 0..Y_RES-1
//  XW       8    x coordinate width (>= clog2(X_RES))
//  YW       7    y coordinate width (>= clog2(Y_RES))
//  COLOR_W  3    colour width (matches vga_adapter BITS_PER_COLOUR_CHANNEL*3)
// PORTS
//  clk        in   1        system clock (CLOCK_50)
//  reset      in   1        asynchronous, active-low reset
//  start      in   1        request level (e.g. ~KEY); one operation per assertion
//  mode       in   2        00 pixel, 01 filled rect, 10 clear screen, 11 outline
//  x0, y0     in   XW/YW    first corner (pixel mode: the pixel)
//  x1, y1     in   XW/YW    opposite corner (ignored in modes 00, 10)
//  color_in   in   COLOR_W  draw colour (forced to 0 in clear mode)
//  x_out      out  XW       pixel x to vga_adapter
//  y_out      out  YW       pixel y to vga_adapter
//  color_out  out  COLOR_W  pixel colour to vga_adapter
//  plot       out  1        write strobe; x_out/y_out/color_out valid when high
//  busy       out  1        high from LOAD until DONE inclusive
//  done       out  1        one-cycle pulse when operation completes
// BEHAVIOUR
//  - All outputs registered. Reset (async, low): state IDLE, x_out=0, y_out=0,
//    color_out=0, plot=0, busy=0, done=0, armed=1. Reset mid-draw aborts instantly;
//    no further plots after release until a new start.
//  - States: IDLE -> LOAD -> DRAW -> DONE -> IDLE.
//  - IDLE: if start=1 and armed=1 -> LOAD; clear armed. armed re-sets only when
//    start is sampled 0 in IDLE or DONE. start ignored outside IDLE.
//  - LOAD (1 cycle): latch mode, colour; clamp each coord to RES-1 (x>=X_RES ->
//    X_RES-1, same for y); order corners: xl=min, xh=max, yl=min, yh=max.
//    Pixel mode: xl=xh=x0, yl=yh=y0. Clear mode: xl=0, xh=X_RES-1, yl=0, yh=Y_RES-1,
//    colour=0. Counters cx=xl, cy=yl.
//  - DRAW: one pixel per cycle, x inner loop, y outer: cx++ until xh, then cx=xl,
//    cy++. Register outputs x_out=cx, y_out=cy, color_out=colour each cycle;
//    plot=1 except in outline mode where plot=1 only if cx in {xl,xh} or cy in
//    {yl,yh} (interior still scanned, plot=0). At cx=xh and cy=yh -> DONE.
//  - DRAW lasts exactly (xh-xl+1)*(yh-yl+1) cycles; first plot appears the cycle
//    after LOAD (2 cycles after start sampled); plot=0 in IDLE/LOAD/DONE.
//  - DONE (1 cycle): done=1, busy still 1; next cycle IDLE, busy=0.
//  - Degenerate rects (xl=xh and/or yl=yh) legal: 1-wide line or 1 pixel; outline
//    of such a rect plots every scanned pixel exactly once.
//  - Counter arithmetic at XW/YW widths; no wrap possible since xh<=X_RES-1.
// TESTING
//  1 mode=00, (x0,y0)=(5,7), color=3'b100, start pulse -> exactly 1 plot at
//    (5,7,100), 2 cycles after start; done 1 cycle after plot; busy 3 cycles.
//  2 mode=01, (2,3)-(4,4), color=3'b010 -> 6 consecutive plots (2,3),(3,3),(4,3),
//    (2,4),(3,4),(4,4); corners swapped (4,4)-(2,3) -> identical sequence.
//  3 mode=01, (150,110)-(200,127) -> clamped to (150..159, 110..119): 100 plots,
//    max x_out=159, max y_out=119.
//  4 mode=10, color_in=3'b111 -> 19200 plots, all color_out=0, raster order,
//    last plot (159,119), then done.
//  5 mode=11, (0,0)-(3,2) -> 12 DRAW cycles, 10 plots, (1,1),(2,1) have plot=0;
//    start held high across done -> no second operation until start drops.
//  6 reset low during clear at pixel ~500 -> plot/busy/done 0 immediately; after
//    release, no plots until new start; new pixel op completes normally.

Source files
------------

// File: rtl/pixel_draw_engine.sv
// Drawing engine for vga_adapter: scans pixel / filled rect / outline / clear-screen
// in raster order, emitting one registered (x, y, colour, plot) write per clock.
module pixel_draw_engine #(
    parameter int X_RES   = 160,
    parameter int Y_RES   = 120,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [XW-1:0]      x0,
    input  logic [YW-1:0]      y0,
    input  logic [XW-1:0]      x1,
    input  logic [YW-1:0]      y1,
    input  logic [COLOR_W-1:0] color_in,
    output logic [XW-1:0]      x_out,
    output logic [YW-1:0]      y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    localparam logic [1:0]    M_PIXEL   = 2'b00;
    localparam logic [1:0]    M_CLEAR   = 2'b10;
    localparam logic [1:0]    M_OUTLINE = 2'b11;
    localparam logic [XW-1:0] XMAX = XW'(X_RES - 1);
    localparam logic [YW-1:0] YMAX = YW'(Y_RES - 1);
    localparam logic [XW-1:0] XONE = XW'(1);
    localparam logic [YW-1:0] YONE = YW'(1);

    state_t               state_q;
    logic                 armed_q;
    logic [1:0]           mode_q;
    logic [COLOR_W-1:0]   col_q, col_d;
    logic [XW-1:0]        xl_q, xh_q, cx_q, xl_d, xh_d, nx_d, xa, xb;
    logic [YW-1:0]        yl_q, yh_q, cy_q, yl_d, yh_d, ny_d, ya, yb;
    logic                 last_d, edge_d;

    // Clamp and order the requested corners; only consumed in LOAD.
    always_comb begin
        xa    = (x0 > XMAX) ? XMAX : x0;
        xb    = (x1 > XMAX) ? XMAX : x1;
        ya    = (y0 > YMAX) ? YMAX : y0;
        yb    = (y1 > YMAX) ? YMAX : y1;
        col_d = color_in;
        xl_d  = (xa < xb) ? xa : xb;
        xh_d  = (xa < xb) ? xb : xa;
        yl_d  = (ya < yb) ? ya : yb;
        yh_d  = (ya < yb) ? yb : ya;
        if (mode == M_PIXEL) begin
            xl_d = xa;
            xh_d = xa;
            yl_d = ya;
            yh_d = ya;
        end else if (mode == M_CLEAR) begin
            xl_d  = '0;
            xh_d  = XMAX;
            yl_d  = '0;
            yh_d  = YMAX;
            col_d = '0;
        end
    end

    // Next scan position and whether it lies on the rectangle border.
    always_comb begin
        last_d = (cx_q == xh_q) && (cy_q == yh_q);
        nx_d   = (cx_q == xh_q) ? xl_q : cx_q + XONE;
        ny_d   = (cx_q == xh_q) ? cy_q + YONE : cy_q;
        edge_d = (nx_d == xl_q) || (nx_d == xh_q) || (ny_d == yl_q) || (ny_d == yh_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            armed_q   <= 1'b1;
            mode_q    <= '0;
            col_q     <= '0;
            xl_q      <= '0;
            xh_q      <= '0;
            yl_q      <= '0;
            yh_q      <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            x_out     <= '0;
            y_out     <= '0;
            color_out <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (!start) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        armed_q <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // First pixel is presented during the first DRAW cycle; it is
                    // always a corner, so it plots in every mode.
                    mode_q    <= mode;
                    col_q     <= col_d;
                    xl_q      <= xl_d;
                    xh_q      <= xh_d;
                    yl_q      <= yl_d;
                    yh_q      <= yh_d;
                    cx_q      <= xl_d;
                    cy_q      <= yl_d;
                    x_out     <= xl_d;
                    y_out     <= yl_d;
                    color_out <= col_d;
                    plot      <= 1'b1;
                    state_q   <= DRAW;
                end
                DRAW: begin
                    if (last_d) begin
                        plot    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cx_q      <= nx_d;
                        cy_q      <= ny_d;
                        x_out     <= nx_d;
                        y_out     <= ny_d;
                        color_out <= col_q;
                        plot      <= (mode_q != M_OUTLINE) || edge_d;
                    end
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    plot    <= 1'b0;
                    if (!start) armed_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_draw_engine.sv
// Scoreboard bench for pixel_draw_engine: a raster-scan reference model queues the
// expected plots and done pulses; a monitor pops and compares on every output event.
module tb_pixel_draw_engine;

    localparam int XR = 160;
    localparam int YR = 120;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = '0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] color_in = '0;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;
    logic       plot, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {int x; int y; int c; bit is_done;} exp_t;
    exp_t exp_q[$];

    pixel_draw_engine dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
        .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: every pixel of the clamped, ordered rectangle in raster order;
    // returns the number of scanned pixels.
    task automatic model(input int m, input int ax, input int ay, input int bx,
                         input int by, input int c, output int n);
        int xa, xb, ya, yb, xl, xh, yl, yh, col;
        xa = (ax > XR-1) ? XR-1 : ax;
        xb = (bx > XR-1) ? XR-1 : bx;
        ya = (ay > YR-1) ? YR-1 : ay;
        yb = (by > YR-1) ? YR-1 : by;
        col = c;
        case (m)
            0: begin xl = xa; xh = xa; yl = ya; yh = ya; end
            2: begin xl = 0; xh = XR-1; yl = 0; yh = YR-1; col = 0; end
            default: begin
                xl = (xa < xb) ? xa : xb; xh = (xa < xb) ? xb : xa;
                yl = (ya < yb) ? ya : yb; yh = (ya < yb) ? yb : ya;
            end
        endcase
        n = 0;
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++) begin
                n++;
                if (m != 3 || x == xl || x == xh || y == yl || y == yh)
                    exp_q.push_back('{x, y, col, 1'b0});
            end
        exp_q.push_back('{0, 0, 0, 1'b1});
    endtask

    // Monitor: every plot or done must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (plot) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    errors++;
                    $display("FAIL plot: unexpected plot at (%0d,%0d,%0d)", x_out, y_out, color_out);
                end else begin
                    if (x_out != exp_q[0].x || y_out != exp_q[0].y || color_out != exp_q[0].c) begin
                        errors++;
                        $display("FAIL pixel: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                 x_out, y_out, color_out, exp_q[0].x, exp_q[0].y, exp_q[0].c);
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    errors++;
                    $display("FAIL done: early or unexpected done, %0d items still queued", exp_q.size());
                end else void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input int m, input int ax, input int ay, input int bx,
                          input int by, input int c, input bit hold);
        int n, k;
        @(negedge clk);
        mode = 2'(m); x0 = 8'(ax); y0 = 7'(ay); x1 = 8'(bx); y1 = 7'(by); color_in = 3'(c);
        model(m, ax, ay, bx, by, c, n);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        chk("busy_in_load", busy, 1);
        chk("plot_in_load", plot, 0);
        k = 0;
        while (!done && k < n + 20) begin
            @(posedge clk);
            k++;
            #1;
        end
        chk("done_latency", k, n + 1);
        chk("busy_in_done", busy, 1);
        @(posedge clk);
        #1;
        chk("busy_after", busy, 0);
        chk("done_pulse", done, 0);
        if (hold) begin
            repeat (5) @(posedge clk);
            #1;
            chk("held_start_idle", busy, 0);
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int n, m, ax, ay, bx, by;
        #3;
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_c", color_out, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #20 reset = 1'b1;

        run_op(0, 5, 7, 0, 0, 3'b100, 0);
        run_op(1, 2, 3, 4, 4, 3'b010, 0);
        run_op(1, 4, 4, 2, 3, 3'b010, 0);
        run_op(1, 150, 110, 200, 127, 3'b001, 0);
        run_op(2, 9, 9, 9, 9, 3'b111, 0);
        run_op(3, 0, 0, 3, 2, 3'b101, 1);
        run_op(3, 7, 4, 7, 9, 3'b011, 0);
        run_op(3, 3, 6, 8, 6, 3'b110, 0);

        // Reset in the middle of a clear.
        @(negedge clk);
        mode = 2'b10; color_in = 3'b111;
        model(2, 0, 0, 0, 0, 7, n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (500) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_after_rst", busy, 0);
        run_op(0, 30, 40, 0, 0, 3'b011, 0);

        for (int i = 0; i < 25; i++) begin
            m  = $urandom_range(0, 2);
            if (m == 2) m = 3;
            ax = $urandom_range(0, 175);
            ay = $urandom_range(0, 127);
            bx = ax + $urandom_range(0, 12) - 6;
            by = ay + $urandom_range(0, 8) - 4;
            if (bx < 0) bx = 0;
            if (bx > 255) bx = 255;
            if (by < 0) by = 0;
            if (by > 127) by = 127;
            run_op(m, ax, ay, bx, by, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
